// File: rtl/sevenseg_bank.sv
// Multi-digit seven-segment controller: registered active-low segment bytes per digit,
// valid/ready frame load, per-digit blink and a scrolling marquee over a blank-padded ring.
module sevenseg_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCROLL_DIV = 12_500_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [7*NUM_DIGITS-1:0]   wr_codes,
  input  logic [1:0]                wr_mode,
  input  logic [NUM_DIGITS-1:0]     wr_blink,
  output logic [8*NUM_DIGITS-1:0]   display
);

  localparam int BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int OFFSET_W = $clog2(2 * NUM_DIGITS);

  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [OFFSET_W-1:0] OFFSET_LAST = OFFSET_W'(2 * NUM_DIGITS - 1);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  state_t                    r_state;
  state_t                    w_stateNext;
  logic                      w_accept;
  logic                      r_ready;
  logic [7*NUM_DIGITS-1:0]   r_codes;
  logic [1:0]                r_mode;
  logic [NUM_DIGITS-1:0]     r_blink;
  logic [BLINK_W-1:0]        r_blinkCnt;
  logic                      r_phase;
  logic [SCROLL_W-1:0]       r_scrollCnt;
  logic [OFFSET_W-1:0]       r_offset;
  logic [8*NUM_DIGITS-1:0]   r_display;
  logic [8*NUM_DIGITS-1:0]   w_nextDisplay;
  logic [6:0]                w_code;
  int                        w_ringIdx;

  function automatic logic [7:0] decodeGlyph(input logic [6:0] code);
    logic [7:0] seg;
    seg = 8'hFF;
    if (code < 7'd32) begin
      case (code[3:0])
        4'h0: seg = 8'hC0;
        4'h1: seg = 8'hF9;
        4'h2: seg = 8'hA4;
        4'h3: seg = 8'hB0;
        4'h4: seg = 8'h99;
        4'h5: seg = 8'h92;
        4'h6: seg = 8'h82;
        4'h7: seg = 8'hF8;
        4'h8: seg = 8'h80;
        4'h9: seg = 8'h90;
        4'hA: seg = 8'h88;
        4'hB: seg = 8'h83;
        4'hC: seg = 8'hC6;
        4'hD: seg = 8'hA1;
        4'hE: seg = 8'h86;
        default: seg = 8'h8E;
      endcase
      seg[7] = ~code[4];
    end else begin
      case (code)
        7'd97:   seg = 8'h7F;
        7'd99:   seg = 8'hBF;
        default: seg = 8'hFF;
      endcase
    end
    return seg;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // r_ready stays low through reset, so the first IDLE cycle after reset cannot accept
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wr_valid && r_ready) begin
          w_accept    = 1'b1;
          w_stateNext = S_COMMIT;
        end
      end
      S_COMMIT: w_stateNext = S_IDLE;
      default:  w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_ready <= 1'b0;
    else        r_ready <= (w_stateNext == S_IDLE);
  end

  // An accept clears the dividers even if they were about to wrap this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_codes     <= {NUM_DIGITS{7'd98}};
      r_mode      <= 2'd0;
      r_blink     <= '0;
      r_blinkCnt  <= '0;
      r_phase     <= 1'b0;
      r_scrollCnt <= '0;
      r_offset    <= '0;
    end else if (w_accept) begin
      r_codes     <= wr_codes;
      r_mode      <= wr_mode;
      r_blink     <= wr_blink;
      r_blinkCnt  <= '0;
      r_phase     <= 1'b0;
      r_scrollCnt <= '0;
      r_offset    <= '0;
    end else begin
      if (r_blinkCnt == BLINK_LAST) begin
        r_blinkCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
      end
      if (r_scrollCnt == SCROLL_LAST) begin
        r_scrollCnt <= '0;
        r_offset    <= (r_offset == OFFSET_LAST) ? '0 : r_offset + OFFSET_W'(1);
      end else begin
        r_scrollCnt <= r_scrollCnt + SCROLL_W'(1);
      end
    end
  end

  // Scroll reads a ring of 2N codes whose upper half is permanently blank
  always_comb begin
    w_nextDisplay = '1;
    w_code        = 7'd98;
    w_ringIdx     = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_code    = r_codes[7*i +: 7];
      w_ringIdx = i + int'(r_offset);
      if (r_mode == 2'd2) begin
        if (w_ringIdx >= 2 * NUM_DIGITS) w_ringIdx = w_ringIdx - 2 * NUM_DIGITS;
        if (w_ringIdx < NUM_DIGITS) w_code = r_codes[7*w_ringIdx +: 7];
        else                        w_code = 7'd98;
      end
      w_nextDisplay[8*i +: 8] = decodeGlyph(w_code);
      if (r_mode == 2'd1 && r_phase && r_blink[i]) w_nextDisplay[8*i +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_display <= '1;
    else        r_display <= w_nextDisplay;
  end

  assign wr_ready = r_ready;
  assign display  = r_display;

endmodule

// File: tb/tb_sevenseg_bank.sv
// Bench for sevenseg_bank: a time-based reference model (cycles since load) checked every
// cycle, plus hand-computed literal expectations for reset, glyphs, blink, scroll and handshake.
module tb_sevenseg_bank;

  localparam int N  = 4;
  localparam int BD = 4;
  localparam int SD = 3;

  localparam logic [7:0] HEX_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [7*N-1:0] wr_codes;
  logic [1:0]    wr_mode;
  logic [N-1:0]  wr_blink;
  logic [8*N-1:0] display;

  int errCount   = 0;
  int checkCount = 0;

  int          mCodes [N];
  int          mMode;
  logic [N-1:0] mBlink;
  int          mT;
  logic [31:0] mDisp;
  logic        mReady;
  bit          mValid = 1'b0;

  sevenseg_bank #(.NUM_DIGITS(N), .BLINK_DIV(BD), .SCROLL_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_codes(wr_codes), .wr_mode(wr_mode), .wr_blink(wr_blink), .display(display)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input int c);
    if (c < 16)  return HEX_TAB[c];
    if (c < 32)  return HEX_TAB[c-16] & 8'h7F;
    if (c == 97) return 8'h7F;
    if (c == 99) return 8'hBF;
    return 8'hFF;
  endfunction

  // Blink phase and scroll offset follow directly from the time elapsed since the load
  function automatic logic [31:0] render(input int codes [N], input int mode,
                                         input logic [N-1:0] blink, input int t);
    logic [31:0] r;
    int phase, off, idx, c;
    r     = '1;
    phase = (t / BD) % 2;
    off   = (t / SD) % (2 * N);
    for (int i = 0; i < N; i++) begin
      c = codes[i];
      if (mode == 2) begin
        idx = (i + off) % (2 * N);
        c   = (idx < N) ? codes[idx] : 98;
      end
      r[8*i +: 8] = glyph(c);
      if (mode == 1 && phase == 1 && blink[i]) r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mDisp  <= '1;
      mReady <= 1'b0;
      for (int i = 0; i < N; i++) mCodes[i] <= 98;
      mMode  <= 0;
      mBlink <= '0;
      mT     <= 0;
    end else begin
      mDisp <= render(mCodes, mMode, mBlink, mT);
      if (mReady && wr_valid) begin
        for (int i = 0; i < N; i++) mCodes[i] <= int'(wr_codes[7*i +: 7]);
        mMode  <= int'(wr_mode);
        mBlink <= wr_blink;
        mT     <= 0;
        mReady <= 1'b0;
      end else begin
        mT     <= mT + 1;
        mReady <= 1'b1;
      end
    end
    mValid <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("modelDisplay", display, mDisp);
      checkOutput("modelReady", {31'b0, wr_ready}, {31'b0, mReady});
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic applyStimulus(input logic [7*N-1:0] codes, input logic [1:0] mode, input logic [N-1:0] blink);
    int budget;
    budget   = 20;
    wr_codes = codes;
    wr_mode  = mode;
    wr_blink = blink;
    wr_valid = 1'b1;
    while (!wr_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("readyWait", {31'b0, wr_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  function automatic logic [7*N-1:0] randomCodes();
    logic [7*N-1:0] v;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) v[7*i +: 7] = 7'(97 + $urandom_range(0, 2));
      else                           v[7*i +: 7] = 7'($urandom_range(0, 127));
    end
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    int accepts;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_codes = '0;
    wr_mode  = 2'd0;
    wr_blink = '0;

    repeat (3) begin
      @(negedge clk);
      checkOutput("resetDisplay", display, 32'hFFFF_FFFF);
      checkOutput("resetReady", {31'b0, wr_ready}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'b0, wr_ready}, 32'd1);

    applyStimulus({7'd3, 7'd2, 7'd1, 7'd0}, 2'd0, 4'b0000);
    checkOutput("commitReadyLow", {31'b0, wr_ready}, 32'd0);
    @(negedge clk);
    checkOutput("staticDisplay", display, 32'hB0A4_F9C0);
    checkOutput("readyBackHigh", {31'b0, wr_ready}, 32'd1);

    applyStimulus({7'd16, 7'd97, 7'd99, 7'd120}, 2'd0, 4'b0000);
    @(negedge clk);
    checkOutput("specialCodes", display, 32'h407F_BFFF);

    applyStimulus({4{7'd8}}, 2'd1, 4'b0101);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      checkOutput("blinkPattern", display, ((j / 4) % 2 == 1) ? 32'h80FF_80FF : 32'h8080_8080);
    end

    applyStimulus({7'd3, 7'd2, 7'd1, 7'd0}, 2'd2, 4'b1111);
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      if (j == 3)  checkOutput("scrollOffset1", display, 32'hFFB0_A4F9);
      if (j == 12) checkOutput("scrollOffset4", display, 32'hFFFF_FFFF);
      if (j == 24) checkOutput("scrollWrap", display, 32'hB0A4_F9C0);
    end

    // Line the first burst accept up with a scroll step so the accept must win
    budget = 50;
    while (!((mT % SD) == SD - 1 && wr_ready) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) checkOutput("collisionOffset", display, 32'hB0A4_F9C0);
      if (c == 0) begin
        wr_codes = {7'd3, 7'd2, 7'd1, 7'd0};
        wr_mode  = 2'd2;
        wr_blink = '0;
      end else begin
        wr_codes = randomCodes();
        wr_mode  = 2'($urandom_range(0, 3));
        wr_blink = 4'($urandom);
      end
      wr_valid = 1'b1;
      if (wr_ready) accepts++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    checkOutput("burstAccepts", 32'(accepts), 32'd3);

    applyStimulus({7'd3, 7'd2, 7'd1, 7'd0}, 2'd2, 4'b0000);
    budget = 60;
    while (((mT / SD) % (2 * N)) != 5 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetDisplay", display, 32'hFFFF_FFFF);
    checkOutput("midResetReady", {31'b0, wr_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus({7'd1, 7'd0, 7'd15, 7'd14}, 2'd0, 4'b0000);
    @(negedge clk);
    checkOutput("postResetStatic", display, 32'hF9C0_8E86);

    repeat (25) begin
      applyStimulus(randomCodes(), 2'($urandom_range(0, 3)), 4'($urandom));
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
